regfile_sb: RTL and testbench



---
 rtl/regfile_pkg.sv | 19 +
 rtl/regfile_scoreboard.sv | 64 ++++++
 rtl/regfile_sb.sv | 105 ++++++++++
 tb/tb_regfile_sb.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
// Shared constants and helpers for the integer register file and its busy
// scoreboard.
//   XLEN_DEFAULT : default data width in bits
//   ZERO_IDX     : index of the hardwired-zero register x0
//   idx_width()  : width of a register index for a given register count
// -----------------------------------------------------------------------------
package regfile_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam int ZERO_IDX     = 0;

  // Index width for n registers; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// -----------------------------------------------------------------------------
// regfile_scoreboard
// One busy bit per architectural register, marking registers that have an
// in-flight producer. Bit 0 is tied low because x0 can never be a producer.
//
// Ports:
//   clk, reset              rising-edge clock, asynchronous active-low reset
//   issue_valid, issue_dest issued instruction will write issue_dest (set)
//   write_enable, dest      writeback to dest (clear)
//   flush                   clear every busy bit, discard same-cycle issue
//   src_one, src_two        lookup indices
//   busy_one, busy_two      registered busy state for the lookup indices
// -----------------------------------------------------------------------------
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter  int NREGS = 32,
  localparam int AW    = idx_width(NREGS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          issue_valid,
  input  logic [AW-1:0] issue_dest,
  input  logic          write_enable,
  input  logic [AW-1:0] dest,
  input  logic          flush,
  input  logic [AW-1:0] src_one,
  input  logic [AW-1:0] src_two,
  output logic          busy_one,
  output logic          busy_two
);

  logic [NREGS-1:0] busy_reg;
  logic [NREGS-1:0] busy_next;

  // Priority per bit: flush clears everything, then a new issue sets the bit
  // (so a newer producer survives a same-cycle writeback), then writeback
  // clears it, otherwise hold.
  generate
    for (genvar gi = 0; gi < NREGS; gi++) begin : g_busy
      if (gi == ZERO_IDX) begin : g_zero
        assign busy_next[gi] = 1'b0;
      end else begin : g_reg
        assign busy_next[gi] =
          flush                                     ? 1'b0 :
          (issue_valid  && (issue_dest == AW'(gi))) ? 1'b1 :
          (write_enable && (dest == AW'(gi)))       ? 1'b0 :
                                                      busy_reg[gi];
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_reg <= '0;
    end else begin
      busy_reg <= busy_next;
    end
  end

  assign busy_one = busy_reg[src_one];
  assign busy_two = busy_reg[src_two];

endmodule

// File: rtl/regfile_sb.sv
// -----------------------------------------------------------------------------
// regfile_sb
// Integer register file for the ID stage: two combinational read ports, one
// synchronous write port, hardwired-zero x0, and a busy scoreboard that
// reports per-source busy flags and a combined stall.
//
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-low reset
//   src_one, src_two      read indices
//   out_one, out_two      read data
//   busy_one, busy_two    source has a pending producer
//   stall                 busy_one | busy_two
//   dest, write_enable,
//   data_in               writeback port
//   issue_valid,
//   issue_dest            issued instruction that will write issue_dest
//   flush                 clear all busy bits at the next edge
//
// Build option: define REGFILE_BYPASS_EN to forward a same-cycle writeback to
// a matching read port (data replaced by data_in, busy forced low).
// -----------------------------------------------------------------------------
module regfile_sb
  import regfile_pkg::*;
#(
  parameter  int XLEN  = XLEN_DEFAULT,
  parameter  int NREGS = 32,
  localparam int AW    = idx_width(NREGS)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [AW-1:0]   src_one,
  input  logic [AW-1:0]   src_two,
  output logic [XLEN-1:0] out_one,
  output logic [XLEN-1:0] out_two,
  output logic            busy_one,
  output logic            busy_two,
  output logic            stall,
  input  logic [AW-1:0]   dest,
  input  logic            write_enable,
  input  logic [XLEN-1:0] data_in,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_dest,
  input  logic            flush
);

  logic [XLEN-1:0] regs_reg [NREGS];
  logic            wr_en;
  logic [XLEN-1:0] rd_one;
  logic [XLEN-1:0] rd_two;
  logic            sb_busy_one;
  logic            sb_busy_two;

  // x0 is never written, so it keeps its reset value of zero.
  assign wr_en = write_enable && (dest != AW'(ZERO_IDX));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_reg[i] <= '0;
      end
    end else if (wr_en) begin
      regs_reg[dest] <= data_in;
    end
  end

  // Explicit zero on x0 reads keeps the guarantee local to the read mux.
  assign rd_one = (src_one == AW'(ZERO_IDX)) ? '0 : regs_reg[src_one];
  assign rd_two = (src_two == AW'(ZERO_IDX)) ? '0 : regs_reg[src_two];

  regfile_scoreboard #(
    .NREGS (NREGS)
  ) u_scoreboard (
    .clk          (clk),
    .reset        (reset),
    .issue_valid  (issue_valid),
    .issue_dest   (issue_dest),
    .write_enable (write_enable),
    .dest         (dest),
    .flush        (flush),
    .src_one      (src_one),
    .src_two      (src_two),
    .busy_one     (sb_busy_one),
    .busy_two     (sb_busy_two)
  );

  always_comb begin
    out_one  = rd_one;
    out_two  = rd_two;
    busy_one = sb_busy_one;
    busy_two = sb_busy_two;
`ifdef REGFILE_BYPASS_EN
    // wr_en already excludes x0, so x0 reads are never forwarded.
    if (wr_en && (src_one == dest)) begin
      out_one  = data_in;
      busy_one = 1'b0;
    end
    if (wr_en && (src_two == dest)) begin
      out_two  = data_in;
      busy_two = 1'b0;
    end
`endif
    stall = busy_one | busy_two;
  end

endmodule

// File: tb/tb_regfile_sb.sv
// -----------------------------------------------------------------------------
// tb_regfile_sb
// Directed-vector bench for regfile_sb with hand-computed expectations.
// Follows REGFILE_BYPASS_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_regfile_sb;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = 5;

  logic            clk;
  logic            reset;
  logic [AW-1:0]   src_one;
  logic [AW-1:0]   src_two;
  logic [XLEN-1:0] out_one;
  logic [XLEN-1:0] out_two;
  logic            busy_one;
  logic            busy_two;
  logic            stall;
  logic [AW-1:0]   dest;
  logic            write_enable;
  logic [XLEN-1:0] data_in;
  logic            issue_valid;
  logic [AW-1:0]   issue_dest;
  logic            flush;

  int vectors;
  int miscompares;

  regfile_sb #(
    .XLEN  (XLEN),
    .NREGS (NREGS)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .src_one      (src_one),
    .src_two      (src_two),
    .out_one      (out_one),
    .out_two      (out_two),
    .busy_one     (busy_one),
    .busy_two     (busy_two),
    .stall        (stall),
    .dest         (dest),
    .write_enable (write_enable),
    .data_in      (data_in),
    .issue_valid  (issue_valid),
    .issue_dest   (issue_dest),
    .flush        (flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    write_enable = 1'b0;
    dest         = '0;
    data_in      = '0;
    issue_valid  = 1'b0;
    issue_dest   = '0;
    flush        = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b0;
    src_one     = '0;
    src_two     = '0;
    idle_inputs();

    // Reset state
    $display("txn: reset asserted");
    repeat (2) tick();
    src_one = 5'd7;
    src_two = 5'd31;
    #1;
    check_val("rst_out_one", out_one, 32'h0);
    check_val("rst_out_two", out_two, 32'h0);
    check_val("rst_busy_one", {31'b0, busy_one}, 32'h0);
    check_val("rst_busy_two", {31'b0, busy_two}, 32'h0);
    check_val("rst_stall", {31'b0, stall}, 32'h0);
    reset = 1'b1;
    tick();

    // x0 protection
    $display("txn: write x0=0xFFFFFFFF, issue x0");
    write_enable = 1'b1; dest = 5'd0; data_in = 32'hFFFF_FFFF;
    issue_valid  = 1'b1; issue_dest = 5'd0;
    src_one = 5'd0; src_two = 5'd0;
    tick();
    idle_inputs();
    #1;
    check_val("x0_out_one", out_one, 32'h0);
    check_val("x0_busy_one", {31'b0, busy_one}, 32'h0);
    check_val("x0_stall", {31'b0, stall}, 32'h0);

    // Scoreboard set then writeback clear
    $display("txn: issue x7");
    issue_valid = 1'b1; issue_dest = 5'd7;
    tick();
    idle_inputs();
    src_one = 5'd7; src_two = 5'd0;
    #1;
    check_val("sb_busy_one_set", {31'b0, busy_one}, 32'h1);
    check_val("sb_stall_set", {31'b0, stall}, 32'h1);
    check_val("sb_busy_two_x0", {31'b0, busy_two}, 32'h0);
    $display("txn: writeback x7=0x1234");
    write_enable = 1'b1; dest = 5'd7; data_in = 32'h0000_1234;
    tick();
    idle_inputs();
    #1;
    check_val("sb_out_one_wb", out_one, 32'h0000_1234);
    check_val("sb_busy_one_clr", {31'b0, busy_one}, 32'h0);
    check_val("sb_stall_clr", {31'b0, stall}, 32'h0);

    // Same-cycle issue and writeback to x3
    $display("txn: issue x3 + writeback x3=0xA5A5A5A5");
    write_enable = 1'b1; dest = 5'd3; data_in = 32'hA5A5_A5A5;
    issue_valid  = 1'b1; issue_dest = 5'd3;
    tick();
    idle_inputs();
    src_one = 5'd3; src_two = 5'd7;
    #1;
    check_val("iw_out_one", out_one, 32'hA5A5_A5A5);
    check_val("iw_busy_one", {31'b0, busy_one}, 32'h1);
    check_val("iw_out_two", out_two, 32'h0000_1234);

    // Issue x1 with writeback x7 to a different index: both take effect
    $display("txn: issue x1 + writeback x7=0x0BADF00D");
    issue_valid = 1'b1; issue_dest = 5'd1;
    write_enable = 1'b1; dest = 5'd7; data_in = 32'h0BAD_F00D;
    tick();
    idle_inputs();
    $display("txn: issue x2");
    issue_valid = 1'b1; issue_dest = 5'd2;
    tick();
    $display("txn: issue x31");
    issue_dest = 5'd31;
    tick();
    idle_inputs();
    src_one = 5'd1; src_two = 5'd2;
    #1;
    check_val("fl_pre_busy_x1", {31'b0, busy_one}, 32'h1);
    check_val("fl_pre_busy_x2", {31'b0, busy_two}, 32'h1);
    src_one = 5'd31; src_two = 5'd7;
    #1;
    check_val("fl_pre_busy_x31", {31'b0, busy_one}, 32'h1);
    check_val("diff_out_x7", out_two, 32'h0BAD_F00D);
    check_val("diff_busy_x7", {31'b0, busy_two}, 32'h0);

    // Flush with same-cycle issue x4 and write x10
    $display("txn: flush + issue x4 + write x10=0xCAFEF00D");
    flush = 1'b1;
    issue_valid = 1'b1; issue_dest = 5'd4;
    write_enable = 1'b1; dest = 5'd10; data_in = 32'hCAFE_F00D;
    tick();
    idle_inputs();
    src_one = 5'd1; src_two = 5'd2;
    #1;
    check_val("fl_busy_x1", {31'b0, busy_one}, 32'h0);
    check_val("fl_busy_x2", {31'b0, busy_two}, 32'h0);
    src_one = 5'd31; src_two = 5'd4;
    #1;
    check_val("fl_busy_x31", {31'b0, busy_one}, 32'h0);
    check_val("fl_busy_x4", {31'b0, busy_two}, 32'h0);
    src_one = 5'd3; src_two = 5'd10;
    #1;
    check_val("fl_busy_x3", {31'b0, busy_one}, 32'h0);
    check_val("fl_stall", {31'b0, stall}, 32'h0);
    check_val("fl_out_x10", out_two, 32'hCAFE_F00D);

    // Bypass: x9 old value with busy set, then rewrite while reading
    $display("txn: issue x9 + write x9=0x11112222");
    write_enable = 1'b1; dest = 5'd9; data_in = 32'h1111_2222;
    issue_valid  = 1'b1; issue_dest = 5'd9;
    tick();
    idle_inputs();
    $display("txn: write x9=0x55AA55AA while reading x9 on both ports");
    write_enable = 1'b1; dest = 5'd9; data_in = 32'h55AA_55AA;
    src_one = 5'd9; src_two = 5'd9;
    #1;
`ifdef REGFILE_BYPASS_EN
    check_val("byp_out_one", out_one, 32'h55AA_55AA);
    check_val("byp_out_two", out_two, 32'h55AA_55AA);
    check_val("byp_busy_one", {31'b0, busy_one}, 32'h0);
    check_val("byp_busy_two", {31'b0, busy_two}, 32'h0);
    check_val("byp_stall", {31'b0, stall}, 32'h0);
`else
    check_val("nobyp_out_one", out_one, 32'h1111_2222);
    check_val("nobyp_out_two", out_two, 32'h1111_2222);
    check_val("nobyp_busy_one", {31'b0, busy_one}, 32'h1);
    check_val("nobyp_busy_two", {31'b0, busy_two}, 32'h1);
    check_val("nobyp_stall", {31'b0, stall}, 32'h1);
`endif
    tick();
    idle_inputs();
    #1;
    check_val("byp_next_out_one", out_one, 32'h55AA_55AA);
    check_val("byp_next_out_two", out_two, 32'h55AA_55AA);
    check_val("byp_next_busy_one", {31'b0, busy_one}, 32'h0);

    // Reset mid-operation
    $display("txn: write x5=0xDEADBEEF");
    write_enable = 1'b1; dest = 5'd5; data_in = 32'hDEAD_BEEF;
    tick();
    idle_inputs();
    $display("txn: issue x5");
    issue_valid = 1'b1; issue_dest = 5'd5;
    tick();
    idle_inputs();
    src_one = 5'd5; src_two = 5'd9;
    #1;
    check_val("mr_pre_out_one", out_one, 32'hDEAD_BEEF);
    check_val("mr_pre_busy_one", {31'b0, busy_one}, 32'h1);
    $display("txn: asynchronous reset between edges");
    #1;
    reset = 1'b0;
    #1;
    check_val("mr_out_one", out_one, 32'h0);
    check_val("mr_busy_one", {31'b0, busy_one}, 32'h0);
    check_val("mr_stall", {31'b0, stall}, 32'h0);
    check_val("mr_out_two", out_two, 32'h0);
    #1;
    reset = 1'b1;

    // First write after reset release
    $display("txn: write x6=0x00000077 after reset release");
    @(negedge clk);
    write_enable = 1'b1; dest = 5'd6; data_in = 32'h0000_0077;
    tick();
    idle_inputs();
    src_one = 5'd6; src_two = 5'd5;
    #1;
    check_val("post_rst_out_x6", out_one, 32'h0000_0077);
    check_val("post_rst_out_x5", out_two, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
